// File: rtl/mux41_sel_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : mux41_sel_sched_if
// Description : Request / select / handshake bundle between the requesters,
//               the mux41 select scheduler and the mux output consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux41_sel_sched_if;
    logic [3:0] req;
    logic       out_ready;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       sel_valid;
    logic       last_beat;

    modport master (
        input  req,
        input  out_ready,
        output sel,
        output grant,
        output sel_valid,
        output last_beat
    );

    modport slave (
        output req,
        output out_ready,
        input  sel,
        input  grant,
        input  sel_valid,
        input  last_beat
    );
endinterface
`default_nettype wire

// File: rtl/mux41_sel_sched.sv
`default_nettype none
// ============================================================================
// Module      : mux41_sel_sched
// Description : Round-robin, dwell-limited select scheduler for mux41 with a
//               valid/ready handshake. MUX41_SCHED_FIXED_PRIO_EN selects
//               fixed priority (channel 0 highest) instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module mux41_sel_sched #(
    parameter int DWELL = 2
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    mux41_sel_sched_if.master   bus
);

    localparam logic [0:0] C_IDLE     = 1'b0;
    localparam logic [0:0] C_GRANT    = 1'b1;
    localparam logic [7:0] C_DWELL_M1 = 8'(DWELL - 1);

    logic [0:0] state_q,  state_d;
    logic [1:0] sel_q,    sel_d;
    logic [3:0] grant_q,  grant_d;
    logic       valid_q,  valid_d;
    logic [7:0] dwell_q,  dwell_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;

    logic       w_accept;
    logic       w_last;
    logic [1:0] w_arb_start;
    logic       w_arb_hit;
    logic [1:0] w_arb_idx;

    assign w_accept = valid_q & bus.out_ready;
    assign w_last   = w_accept & ((dwell_q == 8'd0) | ~bus.req[sel_q]);

    // On a rotating edge the pointer is taken as the outgoing sel, so the
    // search already sees the updated pointer within that same edge.
`ifdef MUX41_SCHED_FIXED_PRIO_EN
    assign w_arb_start = 2'd0;
`else
    assign w_arb_start = ((state_q == C_GRANT) ? sel_q : rr_ptr_q) + 2'd1;
`endif

    // Walk from farthest to nearest so the nearest requester wins.
    always_comb begin
        logic [1:0] cand;
        cand      = 2'd0;
        w_arb_hit = 1'b0;
        w_arb_idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            cand = w_arb_start + 2'(k);
            if (bus.req[cand]) begin
                w_arb_hit = 1'b1;
                w_arb_idx = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= C_IDLE;
            sel_q    <= 2'b00;
            grant_q  <= 4'b0000;
            valid_q  <= 1'b0;
            dwell_q  <= 8'd0;
            rr_ptr_q <= 2'd3;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            grant_q  <= grant_d;
            valid_q  <= valid_d;
            dwell_q  <= dwell_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        grant_d  = grant_q;
        valid_d  = valid_q;
        dwell_d  = dwell_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            C_IDLE: begin
                if (w_arb_hit) begin
                    state_d = C_GRANT;
                    sel_d   = w_arb_idx;
                    grant_d = 4'b0001 << w_arb_idx;
                    valid_d = 1'b1;
                    dwell_d = C_DWELL_M1;
                end
            end
            C_GRANT: begin
                if (w_accept) begin
                    if (!w_last) begin
                        dwell_d = dwell_q - 8'd1;
                    end else begin
                        rr_ptr_d = sel_q;
                        if (w_arb_hit) begin
                            sel_d   = w_arb_idx;
                            grant_d = 4'b0001 << w_arb_idx;
                            dwell_d = C_DWELL_M1;
                        end else begin
                            state_d = C_IDLE;
                            valid_d = 1'b0;
                            grant_d = 4'b0000;
                        end
                    end
                end
            end
            default: begin
                state_d = C_IDLE;
                valid_d = 1'b0;
                grant_d = 4'b0000;
            end
        endcase
    end

    always_comb begin
        bus.sel       = sel_q;
        bus.grant     = grant_q;
        bus.sel_valid = valid_q;
        bus.last_beat = w_last;
    end

endmodule
`default_nettype wire

// File: doc/mux41_sel_sched.md
Name: mux41_sel_sched

Overview:
- Upstream scheduler for the 4-to-1 nibble mux (`mux41`).
- Four requesters raise `req` bits. The block grants them round-robin and drives the mux `sel` with a registered, stable select.
- Each grant lasts at most DWELL accepted beats, with a valid/ready handshake toward the consumer of the mux output.
- Replaces free-running `sel` stimulus with a deterministic, handshaked select source.

Parameters:
- DWELL, 2: maximum beats accepted per grant before rotating. Legal range 1..255.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: synchronous active-low reset, sampled on rising clk.
- req, input, 4: per-channel request; bit n = channel n (mux input i(n+1)) has data.
- out_ready, input, 1: downstream accepts the current mux output this cycle.
- sel, output, 2: registered mux select; connects to `mux41` sel.
- grant, output, 4: registered one-hot of the granted channel; 0 when idle.
- sel_valid, output, 1: registered; high when sel/grant are meaningful and a beat is offered.
- last_beat, output, 1: combinational; sel_valid & out_ready & (dwell_cnt==0 | ~req[sel]).

Behaviour:
- Reset (rst_n=0 at a clk edge): sel=2'b00, grant=4'b0000, sel_valid=0, state=IDLE, dwell_cnt=0, rr_ptr=2'd3 (so channel 0 has first priority). Reset takes effect mid-grant with no completion of the beat in flight.
- States: IDLE, GRANT.
- Arbitration: search from (rr_ptr+1) mod 4 upward with wrap (3 -> 0). Pick the first n with req[n]=1.
- IDLE:
  - If req != 0 at edge k: sel=n, grant=1<<n, sel_valid=1, dwell_cnt=DWELL-1, state=GRANT. Visible in cycle k+1, so latency is 1 cycle from req to sel_valid.
  - Otherwise hold all outputs.
- GRANT, beat accept (sel_valid & out_ready at an edge):
  - If not last beat: dwell_cnt decrements; sel and grant are held.
  - If last beat (dwell_cnt==0 or req[sel]==0 at that edge): rr_ptr=sel. Re-arbitrate in the same edge using the updated pointer.
    - If any req (including the same channel when it is the only requester): load the new grant, sel_valid stays 1 (back-to-back, no bubble), dwell_cnt=DWELL-1.
    - Otherwise: sel_valid=0, grant=0, state=IDLE. sel keeps its last value.
- GRANT, no accept (out_ready=0): sel, grant and dwell_cnt are held regardless of req changes. Withdrawing req only takes effect at the next accepting edge.
- Invariants:
  - sel never changes while sel_valid=1 and out_ready=0.
  - grant is one-hot or zero.
  - grant == (sel_valid ? 1<<sel : 0).
- DWELL=1: every accepted beat rotates the grant.
- Simultaneous requests are resolved purely by rr_ptr order. A request arriving at an edge where the grant rotates is visible to that arbitration.

Optional Feature:
- Macro: MUX41_SCHED_FIXED_PRIO_EN.
- Defined: arbitration ignores rr_ptr and always searches from channel 0 (0 highest, 3 lowest). rr_ptr is still updated but unused. DWELL limit and handshake are unchanged, so a continuously requesting channel 0 regains the grant after each dwell.
- Undefined: round-robin as specified above.

Test Plan:
- Reset check: drive rst_n=0 for 2 cycles with req=4'b1111 -> sel=0, grant=0, sel_valid=0. Release reset, req=4'b0100 -> next cycle sel=2, grant=4'b0100, sel_valid=1.
- Dwell rotation: DWELL=2, req=4'b1111, out_ready=1 constantly -> sel sequence 0,0,1,1,2,2,3,3,0 with no sel_valid gaps. last_beat pulses on every 2nd beat.
- Backpressure: granted channel 1, out_ready=0 for 5 cycles while req toggles to 4'b1000 -> sel stays 1, dwell_cnt unchanged. After out_ready=1, req[1]=0 makes that beat last; the next grant is sel=3.
- Withdraw to idle: single req=4'b0010, out_ready=1, req drops after 1 beat -> sel_valid=0, grant=0 the cycle after the last beat, sel holds 1, then idle until a new req.
- Mid-grant reset: grant on channel 2 with dwell_cnt=1, assert rst_n=0 for 1 cycle -> outputs return to reset values. With req=4'b0101 afterwards, channel 0 is granted first.
- With MUX41_SCHED_FIXED_PRIO_EN: DWELL=2, req=4'b1011, out_ready=1 -> sel sequence 0,0,0,0,...; channel 1 and channel 3 are never granted while req[0]=1.
